// File: rtl/mod_exp_pkg.sv
// Shared types for the square-and-multiply controller: scan states, handshake phases, op kind.
// The LOAD/DONE scan states plus the ARM/WAIT/REL handshake phases form the full controller state.
package mod_exp_pkg;

   localparam int DEF_WIDTH = 32;

   typedef enum logic [1:0] {SC_IDLE, SC_LOAD, SC_MUL, SC_DONE} scan_t;

   typedef enum logic [1:0] {HS_IDLE, HS_ARM, HS_WAIT, HS_REL} hs_t;

   typedef enum logic {OP_SQUARE, OP_MULT} op_t;

endpackage

// File: rtl/mul_req_handshake.sv
// Drives one multiplier request at a time: ARM drops stale done, WAIT captures, REL releases for 1 cycle.
// Latency follows the multiplier; issue is honoured only in IDLE or REL, so the caller waits for rel.
module mul_req_handshake
   import mod_exp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             issue,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] n,
   output logic             capture,
   output logic             rel,
   output logic             mul_start,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   output logic [WIDTH-1:0] mul_n,
   input  logic             mul_done
);

   hs_t state, next;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= HS_IDLE;
      else          state <= next;
   end

   always_comb begin
      next    = state;
      capture = 1'b0;
      rel     = 1'b0;
      case (state)
         HS_IDLE: if (issue) next = HS_ARM;
         // a done still high from the previous request must fall before we trust it
         HS_ARM:  if (!mul_done) next = HS_WAIT;
         HS_WAIT: if (mul_done) begin
            capture = 1'b1;
            next    = HS_REL;
         end
         HS_REL: begin
            rel  = 1'b1;
            next = issue ? HS_ARM : HS_IDLE;
         end
         default: next = HS_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mul_start <= 1'b0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_n     <= '0;
      end else begin
         mul_start <= (next == HS_ARM) || (next == HS_WAIT);
         if (issue && (state == HS_IDLE || state == HS_REL)) begin
            mul_a <= a;
            mul_b <= b;
            mul_n <= n;
         end
      end
   end

endmodule

// File: rtl/mod_exp_ctrl.sv
// MSB-first square-and-multiply M^E mod N over an external multiplier; done pulses after all WIDTH bits.
// Build with MOD_EXP_BALANCED_EN to multiply after every square (zero bits land in a dummy register).
module mod_exp_ctrl
   import mod_exp_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             go,
   input  logic [WIDTH-1:0] M,
   input  logic [WIDTH-1:0] E,
   input  logic [WIDTH-1:0] N,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             mul_start,
   output logic [WIDTH-1:0] mul_a,
   output logic [WIDTH-1:0] mul_b,
   output logic [WIDTH-1:0] mul_n,
   input  logic [WIDTH-1:0] mul_z,
   input  logic             mul_done
);

   localparam int IW = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
   localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
`ifdef MOD_EXP_BALANCED_EN
   localparam logic BALANCED = 1'b1;
`else
   localparam logic BALANCED = 1'b0;
`endif

   scan_t            state, next;
   logic [IW-1:0]    idx;
   logic [WIDTH-1:0] m_q, e_q, n_q;
   // [1] is R, [0] is the dummy sink; every product lands somewhere with the same write path
   logic [WIDTH-1:0] acc_q [2];
   op_t              op_q;

   logic             issue, capture, rel, accept, step, e_bit, wsel;
   logic [WIDTH-1:0] iss_a, iss_b, r;
   op_t              iss_op;

   assign r     = acc_q[1];
   assign e_bit = e_q[idx];
   assign wsel  = (op_q == OP_SQUARE) || e_bit;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= SC_IDLE;
      else          state <= next;
   end

   always_comb begin
      next   = state;
      issue  = 1'b0;
      iss_a  = '0;
      iss_b  = '0;
      iss_op = OP_SQUARE;
      accept = 1'b0;
      step   = 1'b0;
      case (state)
         SC_IDLE: if (go) begin
            accept = 1'b1;
            next   = SC_LOAD;
         end
         SC_LOAD: begin
            if (n_q < TWO) begin
               next = SC_DONE;
            end else begin
               issue = 1'b1;
               iss_a = ONE;
               iss_b = ONE;
               next  = SC_MUL;
            end
         end
         SC_MUL: if (rel) begin
            if (op_q == OP_SQUARE && (e_bit || BALANCED)) begin
               issue  = 1'b1;
               iss_a  = r;
               iss_b  = m_q;
               iss_op = OP_MULT;
            end else if (idx == '0) begin
               next = SC_DONE;
            end else begin
               step  = 1'b1;
               issue = 1'b1;
               iss_a = r;
               iss_b = r;
            end
         end
         SC_DONE: next = SC_IDLE;
         default: next = SC_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         idx      <= '0;
         m_q      <= '0;
         e_q      <= '0;
         n_q      <= '0;
         acc_q[0] <= '0;
         acc_q[1] <= '0;
         op_q     <= OP_SQUARE;
         result   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (accept) begin
            m_q <= M;
            e_q <= E;
            n_q <= N;
            idx <= IW'(WIDTH - 1);
         end
         if (step)  idx  <= idx - IW'(1);
         if (issue) op_q <= iss_op;
         if (state == SC_LOAD) acc_q[1] <= (n_q < TWO) ? '0 : ONE;
         if (capture) acc_q[wsel] <= mul_z;
         busy <= (next != SC_IDLE);
         done <= (next == SC_DONE);
         if (next == SC_DONE) result <= (state == SC_LOAD) ? '0 : r;
      end
   end

   mul_req_handshake #(.WIDTH(WIDTH)) u_hs (
      .clk       (clk),
      .reset_n   (reset_n),
      .issue     (issue),
      .a         (iss_a),
      .b         (iss_b),
      .n         (n_q),
      .capture   (capture),
      .rel       (rel),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_n     (mul_n),
      .mul_done  (mul_done)
   );

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Scoreboard bench for mod_exp_ctrl with a behavioural multiplier (configurable latency, optional stale done).
`timescale 1ns/1ps
module tb_mod_exp_ctrl;

   localparam int W = 32;
   localparam logic [W-1:0] GARB = 32'hDEADBEEF;
`ifdef MOD_EXP_BALANCED_EN
   localparam bit BAL = 1'b1;
`else
   localparam bit BAL = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         go = 1'b0;
   logic [W-1:0] M = '0, E = '0, N = '0;
   logic [W-1:0] result, mul_a, mul_b, mul_n;
   logic [W-1:0] mul_z;
   logic         busy, done, mul_start, mul_done;

   always #5 clk = ~clk;

   mod_exp_ctrl #(.WIDTH(W)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .go        (go),
      .M         (M),
      .E         (E),
      .N         (N),
      .result    (result),
      .busy      (busy),
      .done      (done),
      .mul_start (mul_start),
      .mul_a     (mul_a),
      .mul_b     (mul_b),
      .mul_n     (mul_n),
      .mul_z     (mul_z),
      .mul_done  (mul_done)
   );

   // multiplier model: resets while mul_start is low; stale mode keeps done high
   // (with a garbage product) while idle and for the first 3 cycles of a request
   int lat = 40;
   bit stale_mode = 1'b0;
   int mcnt;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mcnt     <= 0;
         mul_done <= 1'b0;
         mul_z    <= '0;
      end else if (!mul_start) begin
         mcnt <= 0;
         if (stale_mode) begin
            mul_done <= 1'b1;
            mul_z    <= GARB;
         end else begin
            mul_done <= 1'b0;
         end
      end else begin
         mcnt <= mcnt + 1;
         if (mcnt + 1 >= lat) begin
            mul_done <= 1'b1;
            mul_z    <= W'((64'(mul_a) * 64'(mul_b)) % 64'(mul_n));
         end else if (stale_mode && mcnt < 3) begin
            mul_done <= 1'b1;
            mul_z    <= GARB;
         end else begin
            mul_done <= 1'b0;
         end
      end
   end

   typedef struct {
      logic [W-1:0] res;
      int           reqs;
      int           lat;
   } exp_t;

   exp_t sb[$];
   exp_t cur;
   int   n_checks = 0;
   int   n_fail = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   function automatic int exp_reqs(input logic [W-1:0] e);
      return BAL ? 2 * W : W + $countones(e);
   endfunction

   // right-to-left reference, independent of the controller's scan order
   function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] m, input logic [W-1:0] e,
                                               input logic [W-1:0] n);
      logic [63:0] acc, base;
      acc  = 64'd1 % 64'(n);
      base = 64'(m) % 64'(n);
      for (int k = 0; k < W; k++) begin
         if (e[k]) acc = (acc * base) % 64'(n);
         base = (base * base) % 64'(n);
      end
      return W'(acc);
   endfunction

   // monitor: counts requests and busy cycles per operation, pops on every done
   int   rises = 0;
   int   busy_cyc = 0;
   logic prev_start = 1'b0;
   logic prev_busy = 1'b0;
   always @(negedge clk) begin
      if (!reset_n) begin
         prev_start = 1'b0;
         prev_busy  = 1'b0;
      end else begin
         if (busy && !prev_busy) begin
            rises    = 0;
            busy_cyc = 0;
         end
         if (mul_start && !prev_start) rises++;
         if (busy) busy_cyc++;
         if (done) begin
            check("done_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               cur = sb.pop_front();
               check("result", 64'(result), 64'(cur.res));
               check("request_count", 64'(rises), 64'(cur.reqs));
               check("busy_at_done", 64'(busy), 64'd1);
               if (cur.lat > 0) check("go_to_done_cycles", 64'(busy_cyc + 1), 64'(cur.lat));
            end
         end
         prev_start = mul_start;
         prev_busy  = busy;
      end
   end

   task automatic wait_idle();
      int k;
      k = 0;
      @(negedge clk);
      while (busy && k < 5000) begin
         @(negedge clk);
         k++;
      end
      check("wait_idle", 64'(busy), 64'd0);
   endtask

   task automatic start_op(input logic [W-1:0] m, input logic [W-1:0] e, input logic [W-1:0] n,
                           input logic [W-1:0] res, input int reqs, input int l, input bit push);
      exp_t t;
      wait_idle();
      M  = m;
      E  = e;
      N  = n;
      go = 1'b1;
      if (push) begin
         t.res  = res;
         t.reqs = reqs;
         t.lat  = l;
         sb.push_back(t);
      end
      @(negedge clk);
      go = 1'b0;
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, expected completion earlier");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      repeat (3) @(negedge clk);
      #1;
      check("rst_result", 64'(result), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_mul_start", 64'(mul_start), 64'd0);
      check("rst_mul_a", 64'(mul_a), 64'd0);
      check("rst_mul_b", 64'(mul_b), 64'd0);
      check("rst_mul_n", 64'(mul_n), 64'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // main vector, 40-cycle multiplier
      lat = 40;
      start_op(32'd4, 32'd13, 32'd497, 32'd445, exp_reqs(32'd13), 0, 1'b1);

      // E = 0 and degenerate moduli (go cycle, LOAD, DONE)
      wait_idle();
      lat = 5;
      start_op(32'd7, 32'd0, 32'd11, 32'd1, exp_reqs(32'd0), 0, 1'b1);
      start_op(32'd5, 32'd13, 32'd1, 32'd0, 0, 3, 1'b1);
      start_op(32'd5, 32'd13, 32'd0, 32'd0, 0, 3, 1'b1);

      // stale done at every request start
      wait_idle();
      stale_mode = 1'b1;
      lat = 6;
      start_op(32'd3, 32'd5, 32'd7, 32'd5, exp_reqs(32'd5), 0, 1'b1);
      wait_idle();
      stale_mode = 1'b0;
      lat = 5;

      // exponent extremes
      start_op(32'd2, 32'h0000_0001, 32'd1000003, 32'd2, exp_reqs(32'h0000_0001), 0, 1'b1);
      start_op(32'd2, 32'hFFFF_FFFF, 32'd1000003, ref_modexp(32'd2, 32'hFFFF_FFFF, 32'd1000003),
               exp_reqs(32'hFFFF_FFFF), 0, 1'b1);

      // reset mid-WAIT, then a clean run
      wait_idle();
      lat = 40;
      start_op(32'd4, 32'd13, 32'd497, 32'd0, 0, 0, 1'b0);
      k = 0;
      while (!mul_start && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("mul_start_before_reset", 64'(mul_start), 64'd1);
      repeat (10) @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      check("arst_mul_start", 64'(mul_start), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_done", 64'(done), 64'd0);
      check("arst_result", 64'(result), 64'd0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      start_op(32'd4, 32'd13, 32'd497, 32'd445, exp_reqs(32'd13), 0, 1'b1);

      // go pulses while busy must not disturb the running operation
      wait_idle();
      lat = 5;
      start_op(32'd4, 32'd13, 32'd497, 32'd445, exp_reqs(32'd13), 0, 1'b1);
      for (int p = 0; p < 3; p++) begin
         repeat (20 + 40 * p) @(negedge clk);
         check("busy_during_go_pulse", 64'(busy), 64'd1);
         M  = 32'd5;
         E  = 32'd3;
         N  = 32'd11;
         go = 1'b1;
         @(negedge clk);
         go = 1'b0;
      end

      k = 0;
      while (sb.size() != 0 && k < 20000) begin
         @(negedge clk);
         k++;
      end
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      repeat (5) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mod_exp_ctrl.md
# mod_exp_ctrl

Square-and-multiply modular exponentiation controller: computes result = M^E mod N by issuing a sequence of multiply requests to an external modular multiplier over its start/done handshake. It is the initiator end of that interface and sits between the top-level attack target wrapper and the multiplier. The exponent is scanned MSB-first, so the operation sequence, and therefore the power trace, is exponent-dependent unless the balancing option is compiled in.

## Interface
- WIDTH, 32, operand/modulus/exponent width; must match the multiplier's WIDTH
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- go  in  1  single-cycle request; sampled only in IDLE
- M, E, N  in  WIDTH each  base, exponent, modulus; latched on accepted go
- result  out  WIDTH  M^E mod N; valid from the done pulse until the next accepted go
- busy  out  1  high from the cycle after accepted go through the done cycle
- done  out  1  one-cycle completion pulse
- mul_start  out  1  level request to multiplier; multiplier resets while low
- mul_a, mul_b, mul_n  out  WIDTH each  multiplier operands; stable while mul_start is high
- mul_z  in  WIDTH  multiplier product; valid while mul_done is high
- mul_done  in  1  multiplier completion level; may be stale-high at request start

## Operation
- States: IDLE, LOAD, ARM, WAIT, REL, DONE.
- IDLE: on go, latch M/E/N, set bit index i = WIDTH-1, go to LOAD. go while not in IDLE is ignored.
- LOAD: if N < 2, set R = 0 and go to DONE with no requests issued. Otherwise set R = 1, op = SQUARE, and go to ARM with mul_start=1, mul_a=mul_b=R, mul_n=N.
- ARM: hold mul_start; wait for mul_done==0. This discards the stale done still held from the previous request.
- WAIT: hold mul_start; on the first cycle mul_done==1, capture mul_z and go to REL.
- Capture rules:
  - SQUARE: R = mul_z.
  - MULT: R = mul_z when E[i]==1, else a dummy register takes mul_z and R is unchanged.
- REL: mul_start=0 for exactly one cycle, then:
  - After SQUARE: issue MULT (mul_a=R, mul_b=M) if E[i]==1 or the balancing option is enabled. Otherwise advance.
  - After MULT: advance.
  - Advance: if i==0 go to DONE; else i = i-1 and issue SQUARE.
- DONE: result = R, done=1 for one cycle, then IDLE.
- E==0: all squares of 1, result = 1 (N ≥ 2). All WIDTH bits are always processed; leading zeros are not skipped.
- Request count per exponentiation: WIDTH + popcount(E), or 2·WIDTH with balancing.

## Timing
- Reset values: result=0, done=0, busy=0, mul_start=0, mul_a=mul_b=mul_n=0, state IDLE.
- Reset asserted mid-operation: all outputs and state return to reset values immediately. No done is produced, and the multiplier is released by mul_start falling.
- Controller is latency-agnostic. Per request, the controller adds 1 cycle (REL) plus one registered cycle between capture and mul_start rising.
- mul_start is always low for ≥1 full cycle between consecutive requests.
- mul_done high in ARM is never captured. mul_done dropping in WAIT simply keeps the controller waiting.
- The go→done latency for N < 2 is 3 cycles (IDLE→LOAD→DONE).

## Configuration
- MOD_EXP_BALANCED_EN defined: a multiply is issued after every square regardless of E[i]; zero-bit results go to the dummy register. This is the square-and-multiply-always countermeasure, giving an exponent-independent request pattern.
- Undefined: a multiply is issued only for E[i]==1. This is the leaky baseline targeted by the attack.

## Structure
- Package mod_exp_pkg: state encoding, op enum (SQUARE/MULT), default WIDTH.
- One natural sub-module: mul_req_handshake. It owns the ARM/WAIT/REL sequencing and mul_start, and exposes issue/capture strobes to the exponent-scan FSM.

## Test plan
- WIDTH=32, M=4, E=13, N=497, behavioral multiplier with 40-cycle latency -> result=445, one done pulse. Request count is 35 (undefined macro) or 64 (defined).
- E=0, M=7, N=11 -> result=1. N=1 or N=0 -> result=0, done 3 cycles after go, mul_start never rises.
- Multiplier model holding mul_done high for 3 cycles after mul_start rises (stale), with M=3, E=5, N=7 -> result=5. No capture occurs in ARM.
- E=0x00000001 vs E=0xFFFFFFFF, M=2, N=1000003 -> request counts 33/64 without the macro and 64/64 with it; mul_start low ≥1 cycle between every request.
- reset_n pulsed low mid-WAIT -> mul_start, busy, done drop asynchronously, result=0. A following go with M=4, E=13, N=497 -> 445.
- go pulsed while busy -> ignored, and the in-flight result is unchanged.
